// File: rtl/serial_add_ctrl_pkg.sv
// Shared types for the bit-serial adder controller: state encoding and
// the bit-counter width helper.
package serial_add_ctrl_pkg;

    // Encoding 2'd3 is never entered; the next-state logic sends it to S_IDLE.
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // Bit-counter width: enough to count 0..WIDTH-1, never less than one bit.
    function automatic int cnt_width(input int w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

endpackage

// File: rtl/serial_add_ctrl_gfulladd.sv
// gfulladd: combinational 1-bit full-adder cell, time-shared by
// serial_add_ctrl.
module gfulladd (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder controller: adds two WIDTH-bit operands one bit per clock,
// LSB first, through a single full-adder cell with a registered carry.
module serial_add_ctrl
    import serial_add_ctrl_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int CW = cnt_width(WIDTH);

    // Handshake: a transfer happens on a rising clk edge where valid and
    // ready are both 1; in_ready depends only on state, never on in_valid.
    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] sa;
    logic [WIDTH-1:0] sb;
    logic [WIDTH-1:0] sum_r;
    logic             carry;
    logic [CW-1:0]    cnt;
    logic             last_bit;
    logic             fa_s;
    logic             fa_cout;

    assign last_bit = (cnt == CW'(WIDTH - 1));

    gfulladd fa0 (
        .a    (sa[0]),
        .b    (sb[0]),
        .cin  (carry),
        .s    (fa_s),
        .cout (fa_cout)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = S_IDLE;
        case (state)
            S_IDLE:  state_nxt = in_valid ? S_RUN : S_IDLE;
            S_RUN:   state_nxt = last_bit ? S_DONE : S_RUN;
            S_DONE:  state_nxt = out_ready ? S_IDLE : S_DONE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            S_IDLE:  in_ready  = 1'b1;
            S_DONE:  out_valid = 1'b1;
            default: ;
        endcase
    end

    // Sum bits enter at the MSB so that after WIDTH shifts bit 0 lands at sum[0].
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sa    <= '0;
            sb    <= '0;
            sum_r <= '0;
            carry <= 1'b0;
            cnt   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        sa    <= a;
                        sb    <= b;
                        carry <= cin;
                        sum_r <= '0;
                        cnt   <= '0;
                    end
                end
                S_RUN: begin
                    sa    <= sa >> 1;
                    sb    <= sb >> 1;
                    sum_r <= (sum_r >> 1) | (WIDTH'(fa_s) << (WIDTH - 1));
                    carry <= fa_cout;
                    cnt   <= cnt + CW'(1);
                end
                default: ;
            endcase
        end
    end

    assign sum  = sum_r;
    assign cout = carry;

endmodule
